// File: rtl/hermes_buffer.sv
// hermes_buffer: per-port input buffer of the Hermes router.
// Circular flit FIFO plus a packet FSM that requests the switch and streams one packet under credit flow control.
module hermes_buffer #(
    parameter int FLIT_SIZE   = 32,
    parameter int BUFFER_SIZE = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    input  logic [FLIT_SIZE-1:0] data_i,
    output logic                 credit_o,
    output logic                 req_o,
    input  logic                 ack_i,
    output logic                 sending_o,
    output logic [FLIT_SIZE-1:0] data_o,
    output logic                 tx_o,
    input  logic                 credit_i
);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_HEADER,
        S_SIZE,
        S_PAYLOAD
    } state_t;

    logic [FLIT_SIZE-1:0] r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0]     r_head;
    logic [PTR_W-1:0]     r_tail;
    logic [CNT_W-1:0]     r_count;
    state_t               r_state;
    logic [FLIT_SIZE-1:0] r_payload_left;

    logic w_push;
    logic w_pop;
    logic w_not_empty;

    // credit_o depends only on the registered count, so a pop never frees a slot in the same cycle.
    assign w_not_empty = (r_count != '0);
    assign credit_o    = (r_count != FULL_COUNT);
    assign w_push      = rx_i && credit_o;
    assign w_pop       = tx_o && credit_i;

    assign req_o     = (r_state == S_REQ);
    assign sending_o = (r_state == S_HEADER) || (r_state == S_SIZE) || (r_state == S_PAYLOAD);
    assign tx_o      = sending_o && w_not_empty;
    assign data_o    = r_mem[r_head];

    // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_tail] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= S_IDLE;
            r_payload_left <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_not_empty) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack_i) begin
                        r_state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (w_pop) begin
                        r_state <= S_SIZE;
                    end
                end
                S_SIZE: begin
                    // The size flit is the payload length; a zero-length packet ends here.
                    if (w_pop) begin
                        r_payload_left <= data_o;
                        r_state        <= (data_o == '0) ? S_IDLE : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_pop) begin
                        r_payload_left <= r_payload_left - FLIT_SIZE'(1);
                        if (r_payload_left == FLIT_SIZE'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hermes_buffer.sv
// Self-checking bench for hermes_buffer: directed scenarios plus random traffic,
// compared every cycle against a packet-level queue model.
module tb_hermes_buffer;
    localparam int FS = 32;
    localparam int BS = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          rx_i = 1'b0;
    logic [FS-1:0] data_i = '0;
    logic          credit_o;
    logic          req_o;
    logic          ack_i = 1'b0;
    logic          sending_o;
    logic [FS-1:0] data_o;
    logic          tx_o;
    logic          credit_i = 1'b0;

    hermes_buffer #(.FLIT_SIZE(FS), .BUFFER_SIZE(BS)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .rx_i      (rx_i),
        .data_i    (data_i),
        .credit_o  (credit_o),
        .req_o     (req_o),
        .ack_i     (ack_i),
        .sending_o (sending_o),
        .data_o    (data_o),
        .tx_o      (tx_o),
        .credit_i  (credit_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Model: FIFO contents, request pending, packet in flight with pops left and position.
    logic [FS-1:0] m_q[$];
    bit            m_req = 1'b0;
    bit            m_sending = 1'b0;
    int            m_left = 0;
    int            m_pos = 0;

    // Upstream stream: remaining flits of the packet currently being fed in.
    logic [FS-1:0] in_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic gen_packet(input logic [FS-1:0] hdr, input int n);
        in_q.push_back(hdr);
        in_q.push_back(FS'(n));
        for (int i = 0; i < n; i++) in_q.push_back(FS'($urandom));
    endtask

    task automatic model_edge(input bit rx, input logic [FS-1:0] din, input bit ack,
                              input bit cr, input bit rst, output bit pushed);
        bit            credit;
        bit            pop;
        bit            next_req;
        logic [FS-1:0] flit;
        pushed = 1'b0;
        if (rst) begin
            m_q.delete();
            m_req     = 1'b0;
            m_sending = 1'b0;
            return;
        end
        credit   = (m_q.size() != BS);
        pop      = m_sending && (m_q.size() != 0) && cr;
        next_req = m_req ? !ack : (!m_sending && m_q.size() != 0);
        if (pop) begin
            flit = m_q.pop_front();
            if (m_pos == 1) m_left += int'(flit);
            m_left--;
            m_pos++;
            if (m_left == 0) m_sending = 1'b0;
        end
        if (m_req && ack) begin
            m_sending = 1'b1;
            m_left    = 2;
            m_pos     = 0;
        end
        m_req = next_req;
        if (rx && credit) begin
            m_q.push_back(din);
            pushed = 1'b1;
        end
    endtask

    task automatic step(input bit want_rx, input bit ack, input bit cr, input bit rst, input bit gen);
        bit            rx;
        bit            pushed;
        logic [FS-1:0] d;
        @(negedge clk_i);
        check("req_o", 32'(req_o), 32'(m_req));
        check("sending_o", 32'(sending_o), 32'(m_sending));
        check("credit_o", 32'(credit_o), 32'(m_q.size() != BS));
        check("tx_o", 32'(tx_o), 32'(m_sending && m_q.size() != 0));
        check("count", 32'(dut.r_count), 32'(m_q.size()));
        if (m_q.size() != 0) check("data_o", data_o, m_q[0]);
        if (want_rx && !rst && gen && in_q.size() == 0)
            gen_packet(FS'($urandom), int'($urandom_range(0, 4)));
        rx = want_rx && !rst && (in_q.size() != 0);
        d  = rx ? in_q[0] : FS'($urandom);
        rx_i     = rx;
        data_i   = d;
        ack_i    = ack;
        credit_i = cr;
        rst_i    = rst;
        model_edge(rx, d, ack, cr, rst, pushed);
        if (pushed) void'(in_q.pop_front());
        if (rst) in_q.delete();
    endtask

    task automatic run(input int n, input bit cr_random);
        for (int i = 0; i < n; i++)
            step(1'b1, m_req, cr_random ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);

        // Single packet: header 0x0102, three payload flits, continuous credit.
        gen_packet(32'h0102, 3);
        run(16, 1'b0);
        check("single_done_sending", 32'(sending_o), 32'd0);

        // Zero-length packet.
        gen_packet(32'h0A0B, 0);
        run(10, 1'b0);

        // Full buffer: no ack, extra rx attempts are dropped and retried.
        gen_packet(32'h1111, 6);
        gen_packet(32'h2222, 6);
        gen_packet(32'h3333, 2);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("full_credit_low", 32'(credit_o), 32'd0);
        run(40, 1'b0);

        // Backpressure during payload.
        gen_packet(32'h4444, 4);
        for (int i = 0; i < 30 && m_pos < 2; i++) run(1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        run(10, 1'b0);

        // Back-to-back packets queued before the first grant.
        gen_packet(32'h5555, 1);
        gen_packet(32'h6666, 2);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        run(20, 1'b0);

        // Reset in the middle of a payload, then a fresh packet.
        gen_packet(32'h7777, 4);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20 && m_pos < 3; i++) step(1'b0, m_req, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset_count", 32'(m_q.size()), 32'd0);
        gen_packet(32'h8888, 2);
        run(16, 1'b0);

        // Random traffic, including ignored acks, drops and occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 4) != 0,
                 m_req ? 1'($urandom_range(0, 1)) : (($urandom % 8) == 0),
                 ($urandom % 4) != 0,
                 ($urandom % 500) == 0,
                 1'b1);

        // Drain: finish the packet in flight and empty the FIFO.
        for (int i = 0; i < 120; i++) step(1'b1, m_req, 1'b1, 1'b0, 1'b0);
        @(negedge clk_i);
        check("drain_count", 32'(dut.r_count), 32'd0);
        check("drain_sending", 32'(sending_o), 32'd0);
        check("drain_credit", 32'(credit_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/hermes_buffer.md
# hermes_buffer

Per-port input buffer of the Hermes router. It sits directly upstream of the switch: each router instantiates one per port, between the incoming link and the switch/crossbar. It stores incoming flits in a circular FIFO and requests routing from the switch when a header reaches the FIFO head. After the switch acknowledges, it streams the whole packet (header, size flit, payload) out with credit flow control, holding `sending_o` high for the full duration of the packet.

## Interface
- `FLIT_SIZE`, 32, flit width in bits (minimum 20).
- `BUFFER_SIZE`, 8, FIFO depth in flits. Must be a power of 2 and at least 2.

- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `rx_i`  in  1  incoming flit valid.
- `data_i`  in  FLIT_SIZE  incoming flit.
- `credit_o`  out  1  buffer can accept a flit this cycle.
- `req_o`  out  1  routing request to the switch.
- `ack_i`  in  1  one-cycle routing grant from the switch.
- `sending_o`  out  1  packet transmission in progress.
- `data_o`  out  FLIT_SIZE  flit at the FIFO head.
- `tx_o`  out  1  outgoing flit valid.
- `credit_i`  in  1  downstream accepts the flit this cycle.

## Operation
- **FIFO**
  - Storage: `BUFFER_SIZE` entries, plus head and tail pointers of `$clog2(BUFFER_SIZE)` bits each, plus a count of `$clog2(BUFFER_SIZE)+1` bits.
  - Pointers wrap modulo `BUFFER_SIZE`.
  - Push when `rx_i && credit_o`. Pop when `tx_o && credit_i`.
  - Push and pop in the same cycle are both performed and the count is unchanged.
  - `credit_o = (count != BUFFER_SIZE)`. It is a function of registered count only, so there is no combinational path from `credit_i`. When full, a simultaneous pop does not enable a push that cycle.
  - `data_o` is the head entry, driven combinationally from the storage and head pointer. It is stable while no pop occurs, so the switch reads the header from `data_o` during arbitration.
- **Packet format**
  - Flit 0: header, target address in bits [15:0].
  - Flit 1: size N, the payload flit count, in bits [FLIT_SIZE-1:0], unsigned.
  - Flits 2 .. N+1: payload.
- **FSM** (registered state): IDLE, REQ, HEADER, SIZE, PAYLOAD.
  - IDLE: if `count != 0`, go to REQ.
  - REQ: `req_o = 1`. On `ack_i`, go to HEADER. `req_o` is low from the following cycle.
  - HEADER: `sending_o = 1`. On pop, go to SIZE.
  - SIZE: `sending_o = 1`. On pop, load the payload counter with `data_o`. Go to IDLE if the value is 0, otherwise go to PAYLOAD.
  - PAYLOAD: `sending_o = 1`. On each pop, decrement the counter. A pop with counter == 1 goes to IDLE.
- `tx_o = sending_o && (count != 0)`. An empty FIFO mid-packet simply stalls; no flit is lost or duplicated.
- `ack_i` outside REQ is ignored.
- `rx_i` while `credit_o = 0` is ignored; the flit is dropped. The upstream link is responsible for honouring credit.

## Timing
- Reset values:
  - `req_o = 0`, `sending_o = 0`, `tx_o = 0`, `credit_o = 1`, `data_o` = storage[0] (don't care).
  - count = 0, head = tail = 0, state = IDLE.
- Reset asserted mid-packet discards all stored flits and returns to IDLE on the next edge. Storage contents are not cleared.
- A flit pushed in cycle t is visible on `data_o` and counted in cycle t+1. With the FIFO previously empty, `req_o` rises in cycle t+2.
- `ack_i` in cycle a gives `sending_o = 1` and `req_o = 0` in cycle a+1. The header can pop in cycle a+1.
- With continuous credit and data, one flit leaves per cycle.
- A packet of N payload flits occupies N+2 pop cycles.
- `sending_o` falls in the cycle after the last pop; the switch frees the output on that falling edge.
- The next packet's `req_o` can rise in the cycle after returning to IDLE, since IDLE→REQ takes one cycle. `sending_o` is low for at least two cycles between packets.

## Test plan
1. **Single packet.** Push header 0x0102, size 3, payloads A,B,C; pulse `ack_i` when `req_o` is high; hold `credit_i = 1`.
   - `req_o` rises 2 cycles after the first push.
   - Outputs in order: 0x0102, 3, A, B, C on consecutive `tx_o` cycles.
   - `sending_o` falls the cycle after C pops. Count returns to 0.
2. **Zero-length packet.** Size flit 0.
   - FSM goes SIZE→IDLE.
   - Exactly 2 flits are transmitted.
3. **Full buffer (`BUFFER_SIZE = 8`).** Push 8 flits with no ack.
   - `credit_o = 0` after the 8th push, and a 9th `rx_i` is dropped.
   - One pop restores `credit_o` the next cycle.
   - The pointers wrap and data order is preserved across 20 flits.
4. **Backpressure.** Toggle `credit_i` 1,0,0,1 during payload.
   - Pops occur only on `credit_i = 1` cycles.
   - `data_o` holds while stalled. The counter is unchanged on stall cycles.
5. **Back-to-back packets.** Two packets queued.
   - The second `req_o` rises 1 cycle after the first `sending_o` falls.
   - The second header is on `data_o` while `req_o` is high.
6. **Reset mid-payload.** Assert `rst_i` for 1 cycle during PAYLOAD.
   - Next cycle: `sending_o = 0`, `req_o = 0`, `credit_o = 1`, count = 0.
   - A new packet then completes correctly.
